load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the main decoder and ALU.
- Consumes the decoder's memory request, memory write and funct3 controls plus the ALU-computed address and store data.
- Runs one data-memory transaction per instruction over a ready/valid bus, stalling the pipeline until it completes.
- Handles byte-lane alignment, store-data replication, load extraction and sign/zero extension, and detects misalignment.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_memReq  input  1  instruction is a load or store.
- i_memWrite  input  1  1 = store, 0 = load; valid with i_memReq.
- i_funct3  input  3  [1:0] size: 00 byte, 01 half, 10 word; [2] load extension: 0 sign, 1 zero.
- i_addr  input  XLEN  byte address from ALU.
- i_wdata  input  XLEN  store data (rs2).
- i_rd  input  5  load destination register.
- o_dmem_req  output  1  bus request.
- o_dmem_we  output  1  bus write.
- o_dmem_addr  output  XLEN  word-aligned address ({addr[31:2],2'b00}).
- o_dmem_be  output  4  byte enables.
- o_dmem_wdata  output  XLEN  lane-replicated store data.
- i_dmem_ready  input  1  bus accepts request this cycle.
- i_dmem_rvalid  input  1  read data valid.
- i_dmem_rdata  input  XLEN  read word.
- o_stall  output  1  hold upstream stages.
- o_done  output  1  one-cycle completion pulse.
- o_load_valid  output  1  with o_done: load result valid.
- o_load_data  output  XLEN  extended load result.
- o_load_rd  output  5  destination for o_load_data.
- o_misaligned  output  1  one-cycle exception pulse; no bus access.
- o_bus_error  output  1  timeout pulse; tied 0 without LSU_TIMEOUT_EN.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE. All registered outputs, including o_load_data and o_load_rd, are 0. Combinational outputs evaluate to 0 in IDLE when i_memReq=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On i_memReq with an aligned access: latch word address, byte enables, replicated wdata, funct3, addr[1:0], rd and we; next state REQ.
  - Misaligned cases: half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - On a misaligned access: o_misaligned=1 this cycle, no stall, no bus activity, stay IDLE.
- REQ:
  - o_dmem_req=1, with address, be, we and wdata driven from the latched values and held stable until accepted.
  - On i_dmem_ready, a store goes to DONE.
  - On i_dmem_ready, a load goes to WAIT; if i_dmem_rvalid is also 1 the same cycle, it captures data and goes to DONE directly.
- WAIT: on i_dmem_rvalid, capture the extended data and go to DONE.
- DONE:
  - o_done=1 and o_stall=0; o_load_valid = latched ~we; next state IDLE.
  - The same instruction's i_memReq, still present this cycle, is ignored.
- o_stall = (IDLE & i_memReq & aligned) | REQ | WAIT. This gives minimum latency of 3 cycles for a store and 3 for a load with same-cycle rvalid.
- Byte enables: byte = 0001<<addr[1:0]; half = 0011<<{addr[1],0}; word = 1111.
- Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extraction:
  - Shift rdata right by 8*addr[1:0].
  - Take 8, 16 or 32 bits by size.
  - Extend with the MSB if funct3[2]=0, otherwise zero-fill.
- o_load_data and o_load_rd hold their last value until the next load completes.
- i_dmem_rvalid outside REQ/WAIT is ignored; this covers stale responses after reset.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT_CYCLES without the awaited handshake: o_bus_error=1 for one cycle, o_load_data←0, go to DONE (o_done still pulses).
  - Handshake at the exact limit cycle wins over the timeout.
- Undefined: no counter; o_bus_error constant 0; waits indefinitely.

Decomposition:
- Shared package holds:
  - State enum (IDLE/REQ/WAIT/DONE).
  - Size encodings (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10).
  - Byte-enable/replication helper functions.
- One sub-module, load_align: combinational rdata + addr[1:0] + funct3 → extended result. It is reused by any later cache or forwarding path.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ready after 2 cycles → o_dmem_addr=0x100, be=1111, wdata=0xDEADBEEF; stall 3 cycles, then o_done, o_load_valid=0.
- SB addr=0x103, wdata=0x000000A5 → be=1000, wdata=0xA5A5A5A5.
- LB addr=0x201, rdata=0x0000_8000 (byte1=0x80) → o_load_data=0xFFFFFF80; LBU → 0x00000080; o_load_rd equals latched rd.
- LH addr=0x202, rdata=0x80010000 → 0xFFFF8001; ready and rvalid in the same REQ cycle → DONE next cycle.
- LW addr=0x105 → o_misaligned pulse; o_dmem_req never asserted; o_stall=0.
- Assert i_rst_n=0 during WAIT, then release; a late rvalid → state IDLE, no o_done, outputs 0. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, a load with ready but no rvalid → o_bus_error after 4 cycles and o_load_data=0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, access-size
// encodings and the byte-lane helpers used when a request is accepted.
package load_store_unit_pkg;

  localparam int unsigned LSU_XLEN = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } lsu_state_e;

  // Size 11 is reserved and always treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = off[0];
      SZ_W:    is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    byte_en = 4'b0001 << off;
      SZ_H:    byte_en = 4'b0011 << {off[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [LSU_XLEN-1:0] store_rep(input logic [1:0] size,
                                                    input logic [LSU_XLEN-1:0] wdata);
    case (size)
      SZ_B:    store_rep = {4{wdata[7:0]}};
      SZ_H:    store_rep = {2{wdata[15:0]}};
      default: store_rep = wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// load_align: extracts the addressed byte/half/word from a read word and
// sign- or zero-extends it. Purely combinational.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [LSU_XLEN-1:0] rdata_i,
  input  logic [1:0]          off_i,
  input  logic [2:0]          funct3_i,
  output logic [LSU_XLEN-1:0] data_o
);

  logic [LSU_XLEN-1:0] shifted;

  // Shift the addressed lane down to bit 0, then size and extend it.
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    case (funct3_i[1:0])
      SZ_B:    data_o = {{24{~funct3_i[2] & shifted[7]}}, shifted[7:0]};
      SZ_H:    data_o = {{16{~funct3_i[2] & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one data-memory transaction per instruction over a
// ready/valid bus, stalling upstream until it completes.
// Optional: define LSU_TIMEOUT_EN to enable the REQ/WAIT watchdog.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_memReq,
  input  logic            i_memWrite,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_rd,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_ready,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_stall,
  output logic            o_done,
  output logic            o_load_valid,
  output logic [XLEN-1:0] o_load_data,
  output logic [4:0]      o_load_rd,
  output logic            o_misaligned,
  output logic            o_bus_error
);

  if (XLEN != 32 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("load_store_unit: XLEN must be 32 and TIMEOUT_CYCLES nonzero");
  end

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] waddr_q, waddr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic [4:0]      load_rd_q, load_rd_d;
  logic [XLEN-1:0] align_data;
  logic            tmo;
  logic            bus_err;

  load_align u_align (
    .rdata_i  (i_dmem_rdata),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (align_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Watchdog: zero while idle so it starts at 0 on entry to REQ.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                    cnt_q <= '0;
    else if (state_q == S_IDLE)                      cnt_q <= '0;
    else if (state_q == S_REQ || state_q == S_WAIT)  cnt_q <= cnt_q + 1'b1;
  end

  assign tmo = (state_q == S_REQ || state_q == S_WAIT) &&
               (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  assign o_bus_error = bus_err;
  assign o_load_data = load_data_q;
  assign o_load_rd   = load_rd_q;

  // State and latched request registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      load_data_q <= '0;
      load_rd_q   <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      load_data_q <= load_data_d;
      load_rd_q   <= load_rd_d;
    end
  end

  // Next-state, request latching and output decode.
  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    we_d         = we_q;
    load_data_d  = load_data_q;
    load_rd_d    = load_rd_q;
    o_stall      = 1'b0;
    o_done       = 1'b0;
    o_load_valid = 1'b0;
    o_misaligned = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = '0;
    o_dmem_be    = '0;
    o_dmem_wdata = '0;
    bus_err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_memReq) begin
          if (is_misaligned(i_funct3[1:0], i_addr[1:0])) begin
            o_misaligned = 1'b1;
          end else begin
            o_stall  = 1'b1;
            waddr_d  = {i_addr[XLEN-1:2], 2'b00};
            be_d     = byte_en(i_funct3[1:0], i_addr[1:0]);
            wdata_d  = store_rep(i_funct3[1:0], i_wdata);
            funct3_d = i_funct3;
            off_d    = i_addr[1:0];
            rd_d     = i_rd;
            we_d     = i_memWrite;
            state_d  = S_REQ;
          end
        end
      end
      S_REQ: begin
        o_stall      = 1'b1;
        o_dmem_req   = 1'b1;
        o_dmem_we    = we_q;
        o_dmem_addr  = waddr_q;
        o_dmem_be    = be_q;
        o_dmem_wdata = wdata_q;
        if (i_dmem_ready) begin
          if (we_q) begin
            state_d = S_DONE;
          end else if (i_dmem_rvalid) begin
            load_data_d = align_data;
            load_rd_d   = rd_q;
            state_d     = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (tmo) begin
          bus_err     = 1'b1;
          load_data_d = '0;
          state_d     = S_DONE;
        end
      end
      S_WAIT: begin
        o_stall = 1'b1;
        if (i_dmem_rvalid) begin
          load_data_d = align_data;
          load_rd_d   = rd_q;
          state_d     = S_DONE;
        end else if (tmo) begin
          bus_err     = 1'b1;
          load_data_d = '0;
          state_d     = S_DONE;
        end
      end
      default: begin
        o_done       = 1'b1;
        o_load_valid = ~we_q;
        state_d      = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (default build, no watchdog).
module tb_load_store_unit;

  typedef struct {
    logic        is_load;
    logic [31:0] data;
    logic [4:0]  rd;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall, done, load_valid, misaligned, bus_error;
  logic [31:0] load_data;
  logic [4:0]  load_rd;

  sb_entry_t   sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] last_load = '0;
  logic [4:0]  last_rd   = '0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(255)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_memReq      (mem_req),
    .i_memWrite    (mem_write),
    .i_funct3      (funct3),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .i_rd          (rd),
    .o_dmem_req    (dmem_req),
    .o_dmem_we     (dmem_we),
    .o_dmem_addr   (dmem_addr),
    .o_dmem_be     (dmem_be),
    .o_dmem_wdata  (dmem_wdata),
    .i_dmem_ready  (dmem_ready),
    .i_dmem_rvalid (dmem_rvalid),
    .i_dmem_rdata  (dmem_rdata),
    .o_stall       (stall),
    .o_done        (done),
    .o_load_valid  (load_valid),
    .o_load_data   (load_data),
    .o_load_rd     (load_rd),
    .o_misaligned  (misaligned),
    .o_bus_error   (bus_error)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   m_be = (off == 2'd0) ? 4'b0001 : (off == 2'd1) ? 4'b0010 :
                      (off == 2'd2) ? 4'b0100 : 4'b1000;
      2'b01:   m_be = off[1] ? 4'b1100 : 4'b0011;
      default: m_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   m_wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   m_wdata = {d[15:0], d[15:0]};
      default: m_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rw);
    logic [7:0]  b;
    logic [15:0] h;
    b = rw[8*off +: 8];
    h = off[1] ? rw[31:16] : rw[15:0];
    case (f3[1:0])
      2'b00:   m_load = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   m_load = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: m_load = rw;
    endcase
  endfunction

  task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                            input int unsigned rdy_dly, input int unsigned rv_dly,
                            input logic [31:0] rw);
    sb_entry_t   e, got;
    int unsigned k, stalls;
    bit          fin;
    @(negedge clk);
    mem_req = 1'b1; mem_write = we; funct3 = f3; addr = a; wdata = wd; rd = r;
    #1;
    check({tag, ":stall_idle"}, stall, 1);
    check({tag, ":no_misalign"}, misaligned, 0);
    e.is_load = !we;
    e.data    = we ? last_load : m_load(f3, a[1:0], rw);
    e.rd      = we ? last_rd : r;
    sb.push_back(e);
    stalls = 1; fin = 1'b0; k = 0;
    while (!fin && k < 40) begin
      @(negedge clk);
      dmem_ready  = (k == rdy_dly);
      dmem_rvalid = !we && (k == rdy_dly + rv_dly);
      dmem_rdata  = dmem_rvalid ? rw : $urandom;
      #1;
      if (k == 0) begin
        check({tag, ":req"}, dmem_req, 1);
        check({tag, ":we"}, dmem_we, we);
        check({tag, ":addr"}, dmem_addr, {a[31:2], 2'b00});
        check({tag, ":be"}, dmem_be, m_be(f3, a[1:0]));
        check({tag, ":wdata"}, dmem_wdata, m_wdata(f3, wd));
      end
      if (done) begin
        fin = 1'b1;
        got = sb.pop_front();
        check({tag, ":done_stall"}, stall, 0);
        check({tag, ":done_req"}, dmem_req, 0);
        check({tag, ":load_valid"}, load_valid, got.is_load);
        check({tag, ":load_data"}, load_data, got.data);
        check({tag, ":load_rd"}, load_rd, got.rd);
        if (got.is_load) begin
          last_load = got.data;
          last_rd   = got.rd;
        end
      end else if (stall) begin
        stalls++;
      end
      k++;
    end
    check({tag, ":completed"}, fin, 1);
    check({tag, ":stall_cycles"}, stalls, 2 + rdy_dly + (we ? 0 : rv_dly));
    @(negedge clk);
    mem_req = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    #1;
    check({tag, ":idle_req"}, dmem_req, 0);
    check({tag, ":idle_stall"}, stall, 0);
    check({tag, ":idle_done"}, done, 0);
  endtask

  task automatic run_misaligned(input string tag, input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    mem_req = 1'b1; mem_write = 1'b0; funct3 = f3; addr = a;
    #1;
    check({tag, ":misaligned"}, misaligned, 1);
    check({tag, ":stall"}, stall, 0);
    check({tag, ":req"}, dmem_req, 0);
    @(negedge clk);
    mem_req = 1'b0;
    #1;
    check({tag, ":pulse_end"}, misaligned, 0);
    check({tag, ":req_after"}, dmem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv, a;
    logic [2:0]  f3;
    rst_n = 1'b0; mem_req = 1'b0; mem_write = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    rd = '0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst:load_data", load_data, 0);
    check("rst:load_rd", load_rd, 0);
    check("rst:done", done, 0);
    check("rst:stall", stall, 0);
    check("rst:req", dmem_req, 0);
    check("rst:addr", dmem_addr, 0);
    check("rst:be", dmem_be, 0);
    check("rst:bus_error", bus_error, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_access("SW",  1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1,  1, 0, 32'h0);
    run_access("SB",  1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd2,  0, 0, 32'h0);
    run_access("SH",  1'b1, 3'b001, 32'h102, 32'h1234BEEF, 5'd3,  2, 0, 32'h0);
    run_access("LB",  1'b0, 3'b000, 32'h201, 32'h0,        5'd5,  0, 2, 32'h00008000);
    run_access("LBU", 1'b0, 3'b100, 32'h201, 32'h0,        5'd6,  1, 1, 32'h00008000);
    run_access("LH",  1'b0, 3'b001, 32'h202, 32'h0,        5'd7,  0, 0, 32'h80010000);
    run_access("SWh", 1'b1, 3'b010, 32'h104, 32'h0BADF00D, 5'd8,  0, 0, 32'h0);
    run_access("LW",  1'b0, 3'b010, 32'h204, 32'h0,        5'd31, 2, 1, 32'h12345678);
    run_access("LHU", 1'b0, 3'b101, 32'h200, 32'h0,        5'd10, 0, 0, 32'h0000F00D);
    run_access("LB3", 1'b0, 3'b000, 32'h203, 32'h0,        5'd11, 0, 0, 32'h7F000000);

    for (int i = 0; i < 6; i++) begin
      f3 = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      a  = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      rv = $urandom;
      run_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), f3, a, $urandom,
                 5'($urandom_range(0, 31)), $urandom_range(0, 2), $urandom_range(0, 2), rv);
    end

    run_misaligned("MW",  3'b010, 32'h105);
    run_misaligned("MH",  3'b001, 32'h203);
    run_misaligned("MSZ", 3'b011, 32'h100);

    // Reset while a load waits for its data; the late response must be ignored.
    @(negedge clk);
    mem_req = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300; rd = 5'd9;
    @(negedge clk);
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    check("rstw:in_wait_stall", stall, 1);
    rst_n = 1'b0;
    mem_req = 1'b0;
    #1;
    check("rstw:stall", stall, 0);
    check("rstw:load_data", load_data, 0);
    check("rstw:load_rd", load_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEBABE;
    #1;
    check("rstw:late_done", done, 0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    check("rstw:no_done", done, 0);
    check("rstw:no_req", dmem_req, 0);
    check("rstw:no_stall", stall, 0);
    check("rstw:data_zero", load_data, 0);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
